// File: rtl/inst_fetch.sv
// Instruction fetch initiator: owns the fetch PC, drives the synchronous instruction
// memory address and presents each returned word to decode with its PC and a valid flag.
module inst_fetch #(
    parameter int INSTRUCTION_ADDR_WIDTH = 13,
    parameter int INSTRUCTION_WIDTH      = 18,
    parameter logic [INSTRUCTION_ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    output logic [INSTRUCTION_ADDR_WIDTH-1:0] o_mem_address,
    input  logic [INSTRUCTION_WIDTH-1:0]      i_mem_instruction,
    input  logic                              i_stall,
    input  logic                              i_redirect,
    input  logic [INSTRUCTION_ADDR_WIDTH-1:0] i_redirect_pc,
    input  logic                              i_halt,
    output logic [INSTRUCTION_WIDTH-1:0]      o_instruction,
    output logic [INSTRUCTION_ADDR_WIDTH-1:0] o_pc,
    output logic                              o_valid,
    output logic                              o_halted,
    output logic [1:0]                        o_state
);

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [INSTRUCTION_ADDR_WIDTH-1:0] PC_ONE = {{(INSTRUCTION_ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]                        state;
    logic [INSTRUCTION_ADDR_WIDTH-1:0] fpc;

    // Handshake: o_valid qualifies o_instruction/o_pc; while i_stall is high decode does not
    // accept, so the word is held (memory re-reads o_pc) until a cycle with i_stall low.
    always_comb begin
        o_mem_address = fpc;
        if (i_rst) begin
            o_mem_address = RESET_PC;
        end else if (i_redirect) begin
            o_mem_address = i_redirect_pc;
        end else if (state == ST_RUN && i_stall) begin
            o_mem_address = o_pc;
        end
    end

    assign o_instruction = i_mem_instruction;
    assign o_state       = state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_FILL;
            fpc      <= RESET_PC;
            o_pc     <= RESET_PC;
            o_valid  <= 1'b0;
            o_halted <= 1'b0;
        end else begin
            // A redirect is honoured in every state; increments wrap modulo the address space.
            if (i_redirect) begin
                state    <= ST_RUN;
                o_pc     <= i_redirect_pc;
                fpc      <= i_redirect_pc + PC_ONE;
                o_valid  <= 1'b1;
                o_halted <= 1'b0;
            end else begin
                case (state)
                    ST_FILL: begin
                        state   <= ST_RUN;
                        o_pc    <= fpc;
                        fpc     <= fpc + PC_ONE;
                        o_valid <= 1'b1;
                    end
                    ST_RUN: begin
                        if (i_halt) begin
                            state    <= ST_HALTED;
                            o_valid  <= 1'b0;
                            o_halted <= 1'b1;
                        end else if (!i_stall) begin
                            o_pc    <= fpc;
                            fpc     <= fpc + PC_ONE;
                            o_valid <= 1'b1;
                        end
                    end
                    ST_HALTED: begin
                        o_valid  <= 1'b0;
                        o_halted <= 1'b1;
                    end
                    default: begin
                        state   <= ST_FILL;
                        o_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
